// File: rtl/sd_cmd_pkg.sv
// Shared types and frame geometry for the SD command serializer.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CRC   = 2'd2,
    END   = 2'd3
  } sd_cmd_state_t;

  localparam int SD_CMD_FRAME_BITS   = 48;
  localparam int SD_CMD_PAYLOAD_BITS = 40;
  localparam int SD_CMD_CRC_BITS     = 7;

  // Counter values seen on the tick that ends each phase.
  localparam logic [5:0] SD_CMD_SHIFT_LAST = 6'(SD_CMD_PAYLOAD_BITS - 1);
  localparam logic [5:0] SD_CMD_CRC_LAST   = 6'(SD_CMD_PAYLOAD_BITS + SD_CMD_CRC_BITS - 1);

endpackage

// File: rtl/CRC7_D1.sv
// Single-bit CRC7 step, polynomial x^7 + x^3 + 1.
module CRC7_D1 (
  input  logic       new_data,
  input  logic [6:0] curr_crc,
  output logic [6:0] next_crc
);

  logic fb;

  assign fb       = new_data ^ curr_crc[6];
  assign next_crc = {curr_crc[5:3], curr_crc[2] ^ fb, curr_crc[1:0], fb};

endmodule

// File: rtl/sd_cmd_serializer.sv
// Bit-serial SD command transmitter: start, transmission, index, argument,
// CRC7 and end bit, shifted MSB-first, one bit per sd_tick.
//
// state | meaning
// IDLE  | line released, waiting for start
// SHIFT | sending the 40 CRC-covered payload bits
// CRC   | sending the 7 CRC bits
// END   | sending the end bit
module sd_cmd_serializer
  import sd_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  sd_cmd_state_t state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [6:0]  crc_q, crc_d;
  logic [6:0]  crc_step;
  logic        out_d, oe_d, busy_d, done_d;

  // The CRC is fed from the registered line value, which in SHIFT is the
  // shift register MSB, so the CRC always covers exactly what went out.
  CRC7_D1 u_crc7 (
    .new_data (cmd_out),
    .curr_crc (crc_q),
    .next_crc (crc_step)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      crc_q   <= '0;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      cmd_out <= out_d;
      cmd_oe  <= oe_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state and datapath; a tick coincident with start is not counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shift_d = {2'b01, cmd_index, cmd_arg};
          crc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sd_tick) begin
          crc_d   = crc_step;
          shift_d = {shift_q[38:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == SD_CMD_SHIFT_LAST) state_d = CRC;
        end
      end
      CRC: begin
        if (sd_tick) begin
          crc_d = {crc_q[5:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == SD_CMD_CRC_LAST) state_d = END;
        end
      end
      END: begin
        if (sd_tick) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops with no
  // combinational path from the inputs.
  always_comb begin
    out_d  = 1'b1;
    oe_d   = 1'b1;
    busy_d = 1'b1;
    done_d = (state_q == END) && sd_tick;
    case (state_d)
      IDLE: begin
        oe_d   = 1'b0;
        busy_d = 1'b0;
      end
      SHIFT:   out_d = shift_d[39];
      CRC:     out_d = crc_d[6];
      default: out_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
module tb_sd_cmd_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_tick;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  localparam logic [47:0] FRAME_CMD0  = 48'h40_00000000_95;
  localparam logic [47:0] FRAME_CMD8  = 48'h48_000001AA_87;
  localparam logic [47:0] FRAME_CMD17 = 48'h51_00000000_55;
  localparam logic [47:0] FRAME_CMD55 = 48'h77_00000000_65;

  sd_cmd_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sd_tick   (sd_tick),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Cycles from one tick to the next for bit k.
  function automatic int gap_of(input int k, input int mode);
    if (mode == 0) return 4;
    if (k == 42) return 100;
    case (k % 3)
      0:       return 1;
      1:       return 7;
      default: return 2;
    endcase
  endfunction

  // Called at a negedge. Drives one-cycle start, then returns at the next negedge.
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic with_tick);
    start     = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    sd_tick   = with_tick;
    @(negedge clk);
    start     = 1'b0;
    sd_tick   = 1'b0;
    cmd_index = ~idx;
    cmd_arg   = ~arg;
  endtask

  // Called at a negedge. Issues n ticks, capturing the bit driven before each.
  task automatic run_ticks(input int n, input int mode, input int restart_k,
                           output logic [47:0] bits, output int bad_oe,
                           output int bad_stable, output int bad_done);
    logic prev;
    bits = '0;
    bad_oe = 0;
    bad_stable = 0;
    bad_done = 0;
    for (int k = 0; k < n; k++) begin
      prev = cmd_out;
      for (int c = 0; c < gap_of(k, mode) - 1; c++) begin
        @(negedge clk);
        if (cmd_out !== prev) bad_stable++;
      end
      if (cmd_oe !== 1'b1 || busy !== 1'b1) bad_oe++;
      if (done !== 1'b0) bad_done++;
      bits[47-k] = cmd_out;
      sd_tick = 1'b1;
      if (k == restart_k) begin
        start     = 1'b1;
        cmd_index = 6'd17;
        cmd_arg   = 32'hDEADBEEF;
      end
      @(negedge clk);
      sd_tick = 1'b0;
      start   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sd_tick = 1'b0;
    start = 1'b0;
    cmd_index = '0;
    cmd_arg = '0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_out !== 1'b1) begin errors++; $display("FAIL reset_cmd_out: got %b want 1", cmd_out); end
    checks++; if (cmd_oe !== 1'b0)  begin errors++; $display("FAIL reset_cmd_oe: got %b want 0", cmd_oe); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, cmd_oe, cmd_out} !== 3'b001) begin errors++; $display("FAIL idle_after_reset: got %b want 001", {busy, cmd_oe, cmd_out}); end
  endtask

  task automatic test_frame(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [47:0] expect_bits, input int mode, input logic with_tick);
    logic [47:0] bits;
    int bad_oe, bad_stable, bad_done;
    start_cmd(idx, arg, with_tick);
    checks++; if ({busy, cmd_oe, cmd_out} !== 3'b110) begin errors++; $display("FAIL accept_cmd%0d: busy/oe/out got %b want 110", idx, {busy, cmd_oe, cmd_out}); end
    run_ticks(48, mode, -1, bits, bad_oe, bad_stable, bad_done);
    checks++; if (bits !== expect_bits) begin errors++; $display("FAIL frame_cmd%0d: got %h want %h", idx, bits, expect_bits); end
    checks++; if (bad_oe !== 0) begin errors++; $display("FAIL oe_busy_cmd%0d: %0d bad bit periods, want 0", idx, bad_oe); end
    checks++; if (bad_stable !== 0) begin errors++; $display("FAIL stable_cmd%0d: %0d off-tick changes, want 0", idx, bad_stable); end
    checks++; if (bad_done !== 0) begin errors++; $display("FAIL early_done_cmd%0d: %0d early pulses, want 0", idx, bad_done); end
    checks++; if ({done, busy, cmd_oe, cmd_out} !== 4'b1001) begin errors++; $display("FAIL end_cmd%0d: done/busy/oe/out got %b want 1001", idx, {done, busy, cmd_oe, cmd_out}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width_cmd%0d: got %b want 0", idx, done); end
  endtask

  task automatic test_restart_ignored();
    logic [47:0] bits;
    int bad_oe, bad_stable, bad_done, idle_bad;
    start_cmd(6'd8, 32'h000001AA, 1'b0);
    run_ticks(48, 0, 20, bits, bad_oe, bad_stable, bad_done);
    checks++; if (bits !== FRAME_CMD8) begin errors++; $display("FAIL restart_frame: got %h want %h", bits, FRAME_CMD8); end
    checks++; if (bad_oe !== 0 || bad_done !== 0) begin errors++; $display("FAIL restart_flags: oe_bad=%0d done_bad=%0d want 0", bad_oe, bad_done); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      sd_tick = i[0];
      @(negedge clk);
      if (cmd_oe !== 1'b0 || busy !== 1'b0 || cmd_out !== 1'b1) idle_bad++;
    end
    sd_tick = 1'b0;
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL restart_second_frame: %0d active cycles, want 0", idle_bad); end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] bits;
    int bad_oe, bad_stable, bad_done;
    start_cmd(6'd0, 32'h0, 1'b0);
    run_ticks(30, 0, -1, bits, bad_oe, bad_stable, bad_done);
    checks++; if (cmd_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before_reset: got %b want 1", cmd_oe); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_oe, cmd_out, busy} !== 3'b010) begin errors++; $display("FAIL async_reset: oe/out/busy got %b want 010", {cmd_oe, cmd_out, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_frame(6'd0, 32'h0, FRAME_CMD0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [47:0] bits;
    int bad_oe, bad_stable, bad_done;
    start_cmd(6'd17, 32'h0, 1'b0);
    run_ticks(48, 0, -1, bits, bad_oe, bad_stable, bad_done);
    checks++; if (bits !== FRAME_CMD17) begin errors++; $display("FAIL b2b_frame1: got %h want %h", bits, FRAME_CMD17); end
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done_cycle: done/busy got %b want 10", {done, busy}); end
    start_cmd(6'd55, 32'h0, 1'b0);
    checks++; if ({busy, cmd_oe, cmd_out, done} !== 4'b1100) begin errors++; $display("FAIL b2b_accept: busy/oe/out/done got %b want 1100", {busy, cmd_oe, cmd_out, done}); end
    run_ticks(48, 0, -1, bits, bad_oe, bad_stable, bad_done);
    checks++; if (bits !== FRAME_CMD55) begin errors++; $display("FAIL b2b_frame2: got %h want %h", bits, FRAME_CMD55); end
    checks++; if ({done, busy, cmd_oe} !== 3'b100) begin errors++; $display("FAIL b2b_end: done/busy/oe got %b want 100", {done, busy, cmd_oe}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame(6'd0, 32'h0, FRAME_CMD0, 0, 1'b0);
    test_frame(6'd8, 32'h000001AA, FRAME_CMD8, 0, 1'b0);
    test_restart_ignored();
    test_reset_mid_frame();
    test_frame(6'd8, 32'h000001AA, FRAME_CMD8, 1, 1'b1);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
